mskaes_32bits_key_ctrl: RTL and testbench
=========================================

// Module: mskaes_32bits_key_ctrl
// PURPOSE
// - Sequences the masked 32-bit key datapath through a full AES-128 key schedule (forward or inverse).
// - Loads the shared key, requests the shared S-box column slot, times the 4 column updates and steps RCON.
// - Flags each completed round key to the top-level control. Handles control signals only; never touches shares.
// PARAMETERS
// - SBOX_LAT  4   cycles from S-box grant to valid sh_4bytes_from_SB (>=1)
// - NROUNDS   10  number of round-key derivations per run
// PORTS
// - clk                     in  1  single clock, all flops rising edge
// - rst                     in  1  asynchronous, active-high; forces IDLE
// - start                   in  1  begin run; sampled in IDLE only
// - inverse                 in  1  mode select, latched on accepted start
// - abort                   in  1  synchronous; returns to IDLE on next edge
// - sb_gnt                  in  1  shared S-box granted to key column this cycle
// - sb_req                  out 1  key column requests shared S-box
// - init, enable, loop      out 1  key datapath register load/enable/rotate
// - add_from_sb             out 1  select S-box result for column-0 update
// - rcon_rst, rcon_update   out 1  RCON unit reset / step
// - rcon_inverse            out 1  latched inverse mode, held while busy
// - enable_buffer_from_sbox out 1  inverse-path buffer enable
// - rst_buffer_from_sbox    out 1  inverse-path buffer clear
// - busy                    out 1  high from accepted start until done or abort
// - round_key_valid         out 1  1-cycle pulse: stored key holds a new round key
// - round_idx               out 4  index of last completed round (0 = master key)
// - done                    out 1  1-cycle pulse after round NROUNDS
// BEHAVIOUR
// - Moore outputs decoded from state. After rst every output is 0, round_idx=0, mode latch 0.
// - IDLE: all strobes 0. start=1 -> LOAD. start while busy is ignored.
// - LOAD (1 cycle): init=1, enable=1, rcon_rst=1; inverse mode also rst_buffer=1, enable_buffer=1.
//   round_key_valid=1 with round_idx=0 on the following cycle. -> REQ.
// - REQ: sb_req=1, enable=0 (key held). sb_gnt=1 is the send cycle -> WAIT. Stall is unbounded.
// - WAIT: SBOX_LAT-1 cycles, enable=0, sb_req=0. With SBOX_LAT=1, WAIT is skipped.
// - UPD (4 cycles, c=0..3): enable=1, loop=0, add_from_sb=(c==0).
//   Inverse mode: enable_buffer=1 for all c; rst_buffer=1 at c==3.
//   c==3 also: rcon_update=1, round counter +1.
//   Next cycle: round_key_valid pulse, round_idx = new count.
// - Round length with immediate grant: 1+(SBOX_LAT-1)+4 = SBOX_LAT+4 cycles (8 by default).
// - After UPD of round NROUNDS -> FIN (1 cycle): done=1, busy=0 -> IDLE. Otherwise -> REQ.
// - round_key_valid and done coincide for the final round.
// - abort in any state: next edge goes to IDLE with all strobes 0 and busy=0.
//   A pending sb_req drops, round_idx is kept, and no done pulse is issued.
// - abort and start in the same cycle while in IDLE: abort wins.
// - rst mid-run: immediate IDLE. Datapath register contents are not cleared.
// - sb_gnt seen outside REQ: ignored.
// - loop is 0 throughout a run. It is asserted only while IDLE and start_rotate is given
//   (not exposed; tied 0 in this revision).
// - rcon_inverse changes only on an accepted start. It is never toggled mid-run.
// STRUCTURE
// - Shared package mskaes_ctrl_pkg:
//   - state enum {IDLE, LOAD, REQ, WAIT, UPD, FIN}
//   - KEY_COLS=4, round-count width constant
// - One sub-module: mskaes_lat_counter. Down-counter shared by WAIT (SBOX_LAT-1) and UPD (4),
//   with load/zero flag.
// - Round counter, mode latch and FSM stay in the top of this block.
// TESTING
// - Forward, sb_gnt tied 1: start@0 -> init@1.
//   enable pulses on 4 consecutive cycles per round; rcon_update 10 times.
//   done at cycle 2+10*8; round_idx ends at 10.
// - Grant stall: hold sb_gnt=0 for 5 cycles in round 3 -> sb_req stays 1 and enable stays 0.
//   That round stretches exactly 5 cycles; all other timing is unchanged.
// - Inverse: inverse=1 at start -> rcon_inverse=1 for the whole run.
//   rst_buffer at LOAD and at each UPD c==3; enable_buffer on 4 cycles per round.
// - abort in WAIT of round 5 -> IDLE next cycle, busy=0, no done, round_idx=4.
//   A fresh start then reruns from round 0.
// - rst asserted mid-UPD -> all outputs 0 asynchronously.
//   start during busy is ignored: a single done only.
// - SBOX_LAT=1 build: grant cycle is followed directly by UPD, giving a 5-cycle round.

Source files
------------

// File: rtl/mskaes_ctrl_pkg.sv
// Shared types and constants for the masked AES key-schedule controller.
package mskaes_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    UPD  = 3'd4,
    FIN  = 3'd5
  } state_t;

  localparam int KEY_COLS = 4;
  localparam int RND_W    = 4;

endpackage

// File: rtl/mskaes_lat_counter.sv
// Down-counter with load and zero flag; times both the S-box wait and the column updates.
module mskaes_lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (!zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mskaes_32bits_key_ctrl.sv
// Control FSM for the masked 32-bit AES-128 key schedule: load, S-box slot request,
// column updates, RCON stepping and round-key flagging. Never touches key shares.
//   state | meaning
//   IDLE  | waiting for start, all strobes low
//   LOAD  | master key loaded into datapath, RCON reset
//   REQ   | requesting shared S-box, key held
//   WAIT  | S-box pipeline latency
//   UPD   | four column updates, last one steps RCON
//   FIN   | done pulse, back to IDLE
module mskaes_32bits_key_ctrl
  import mskaes_ctrl_pkg::*;
#(
  parameter int SBOX_LAT = 4,
  parameter int NROUNDS  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inverse,
  input  logic             abort,
  input  logic             sb_gnt,
  output logic             sb_req,
  output logic             init,
  output logic             enable,
  output logic             loop,
  output logic             add_from_sb,
  output logic             rcon_rst,
  output logic             rcon_update,
  output logic             rcon_inverse,
  output logic             enable_buffer_from_sbox,
  output logic             rst_buffer_from_sbox,
  output logic             busy,
  output logic             round_key_valid,
  output logic [RND_W-1:0] round_idx,
  output logic             done
);

  localparam int CNT_MAX = (SBOX_LAT > KEY_COLS) ? SBOX_LAT : KEY_COLS;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] UPD_LOAD  = CNT_W'(KEY_COLS - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((SBOX_LAT > 1) ? SBOX_LAT - 2 : 0);
  localparam logic [RND_W-1:0] LAST_RND  = RND_W'(NROUNDS - 1);

  state_t           state;
  logic             mode_q;
  logic             rkv_q;
  logic [RND_W-1:0] round_cnt;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             start_rotate;
  logic             col_first;

  // Rotation-only mode is not exposed in this revision.
  assign start_rotate = 1'b0;

  mskaes_lat_counter #(.W(CNT_W)) u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = UPD_LOAD;
    if (!abort) begin
      case (state)
        REQ: if (sb_gnt) begin
          cnt_load = 1'b1;
          cnt_val  = (SBOX_LAT > 1) ? WAIT_LOAD : UPD_LOAD;
        end
        WAIT: if (cnt_zero) cnt_load = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      rkv_q     <= 1'b0;
      round_cnt <= '0;
    end else begin
      rkv_q <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) begin
            state     <= LOAD;
            mode_q    <= inverse;
            round_cnt <= '0;
          end
          LOAD: begin
            state <= REQ;
            rkv_q <= 1'b1;
          end
          REQ:  if (sb_gnt) state <= (SBOX_LAT > 1) ? WAIT : UPD;
          WAIT: if (cnt_zero) state <= UPD;
          UPD: if (cnt_zero) begin
            round_cnt <= round_cnt + 1'b1;
            rkv_q     <= 1'b1;
            state     <= (round_cnt == LAST_RND) ? FIN : REQ;
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Column index runs 0..3 while the counter runs 3..0, so c==3 is the zero flag.
  assign col_first = (cnt == UPD_LOAD);

  always_comb begin
    sb_req                  = (state == REQ);
    init                    = (state == LOAD);
    enable                  = (state == LOAD) || (state == UPD);
    loop                    = (state == IDLE) && start_rotate;
    add_from_sb             = (state == UPD) && col_first;
    rcon_rst                = (state == LOAD);
    rcon_update             = (state == UPD) && cnt_zero;
    enable_buffer_from_sbox = mode_q && ((state == LOAD) || (state == UPD));
    rst_buffer_from_sbox    = mode_q && ((state == LOAD) || ((state == UPD) && cnt_zero));
    busy                    = (state != IDLE) && (state != FIN);
  end

  assign rcon_inverse    = mode_q;
  assign round_key_valid = rkv_q;
  assign round_idx       = round_cnt;
  assign done            = (state == FIN);

endmodule

// File: tb/tb_mskaes_32bits_key_ctrl.sv
// Self-checking bench: expected per-cycle outputs come from a schedule computed with
// round-length arithmetic, compared against a default build and an SBOX_LAT=1 build.
module tb_mskaes_32bits_key_ctrl;

  localparam int NR   = 10;
  localparam int MAXC = 256;

  logic clk = 1'b0;
  logic rst, start, inverse, abort, sb_gnt;
  int   sel;
  int   total = 0;
  int   bad   = 0;
  int   printed = 0;
  bit   prev_mode [0:1];
  logic [3:0] prev_idx [0:1];

  always #5 clk = ~clk;

  logic start0, abort0, gnt0, start1, abort1, gnt1;
  assign start0 = (sel == 0) && start;
  assign abort0 = (sel == 0) && abort;
  assign gnt0   = (sel == 0) && sb_gnt;
  assign start1 = (sel == 1) && start;
  assign abort1 = (sel == 1) && abort;
  assign gnt1   = (sel == 1) && sb_gnt;

  logic       sbr0, ini0, en0, lp0, add0, rr0, ru0, ri0, eb0, rb0, bsy0, rkv0, dn0;
  logic [3:0] idx0;
  logic       sbr1, ini1, en1, lp1, add1, rr1, ru1, ri1, eb1, rb1, bsy1, rkv1, dn1;
  logic [3:0] idx1;

  mskaes_32bits_key_ctrl #(.SBOX_LAT(4), .NROUNDS(NR)) u_dut (
    .clk(clk), .rst(rst), .start(start0), .inverse(inverse), .abort(abort0), .sb_gnt(gnt0),
    .sb_req(sbr0), .init(ini0), .enable(en0), .loop(lp0), .add_from_sb(add0),
    .rcon_rst(rr0), .rcon_update(ru0), .rcon_inverse(ri0),
    .enable_buffer_from_sbox(eb0), .rst_buffer_from_sbox(rb0), .busy(bsy0),
    .round_key_valid(rkv0), .round_idx(idx0), .done(dn0)
  );

  mskaes_32bits_key_ctrl #(.SBOX_LAT(1), .NROUNDS(NR)) u_dut_lat1 (
    .clk(clk), .rst(rst), .start(start1), .inverse(inverse), .abort(abort1), .sb_gnt(gnt1),
    .sb_req(sbr1), .init(ini1), .enable(en1), .loop(lp1), .add_from_sb(add1),
    .rcon_rst(rr1), .rcon_update(ru1), .rcon_inverse(ri1),
    .enable_buffer_from_sbox(eb1), .rst_buffer_from_sbox(rb1), .busy(bsy1),
    .round_key_valid(rkv1), .round_idx(idx1), .done(dn1)
  );

  // Bit layout: 16 sb_req,15 init,14 enable,13 loop,12 add,11 rcon_rst,10 rcon_update,
  // 9 rcon_inverse,8 en_buf,7 rst_buf,6 busy,5 rkv,4 done,3:0 round_idx
  logic [16:0] obs0, obs1, obs;
  assign obs0 = {sbr0, ini0, en0, lp0, add0, rr0, ru0, ri0, eb0, rb0, bsy0, rkv0, dn0, idx0};
  assign obs1 = {sbr1, ini1, en1, lp1, add1, rr1, ru1, ri1, eb1, rb1, bsy1, rkv1, dn1, idx1};
  assign obs  = (sel == 1) ? obs1 : obs0;

  function automatic logic [16:0] idle_vec(input bit m, input logic [3:0] idx);
    logic [16:0] v;
    v = '0;
    v[9] = m;
    v[3:0] = idx;
    return v;
  endfunction

  task automatic run_sched(input int inst, input bit inv, input int stall [1:NR],
                           input int abort_at, input bit rand_start, input string name,
                           output int n_en, output int n_upd, output int n_done,
                           output int done_cyc, output logic [3:0] last_idx);
    logic [16:0] expv [0:MAXC-1];
    bit in_req [0:MAXC-1];
    bit hold [0:MAXC-1];
    int lat, t, g, u0, fin, ncyc, lim;
    lat = (inst == 1) ? 1 : 4;
    for (int c = 0; c < MAXC; c++) begin
      expv[c] = (c == 0) ? idle_vec(prev_mode[inst], prev_idx[inst]) : idle_vec(inv, 4'd0);
      in_req[c] = 1'b0;
      hold[c] = 1'b0;
    end
    expv[1][15] = 1'b1; expv[1][14] = 1'b1; expv[1][11] = 1'b1; expv[1][6] = 1'b1;
    expv[1][8] = inv;   expv[1][7] = inv;
    t = 2;
    for (int r = 1; r <= NR; r++) begin
      expv[t][5] = 1'b1;
      g = t + stall[r];
      for (int c = t; c <= g; c++) begin
        expv[c][16] = 1'b1; expv[c][6] = 1'b1;
        in_req[c] = 1'b1;
        hold[c] = (c < g);
      end
      for (int c = g + 1; c < g + lat; c++) expv[c][6] = 1'b1;
      u0 = g + lat;
      for (int k = 0; k < 4; k++) begin
        expv[u0+k][14] = 1'b1; expv[u0+k][6] = 1'b1;
        expv[u0+k][12] = (k == 0);
        expv[u0+k][8] = inv;
        expv[u0+k][10] = (k == 3);
        expv[u0+k][7] = inv && (k == 3);
      end
      for (int c = u0 + 4; c < MAXC; c++) expv[c][3:0] = 4'(r);
      t = u0 + 4;
    end
    fin = t;
    expv[fin][4] = 1'b1;
    expv[fin][5] = 1'b1;
    ncyc = fin + 3;
    if (abort_at >= 1 && abort_at < fin) begin
      for (int c = abort_at + 1; c < MAXC; c++) expv[c] = idle_vec(inv, expv[abort_at][3:0]);
      ncyc = abort_at + 4;
    end
    lim = (abort_at >= 1 && abort_at < fin) ? abort_at + 1 : fin;

    n_en = 0; n_upd = 0; n_done = 0; done_cyc = -1;
    sel = inst;
    for (int c = 0; c < ncyc; c++) begin
      start   = (c == 0) || (rand_start && c < lim && ($urandom_range(0, 3) == 0));
      inverse = (c == 0) ? inv : 1'($urandom_range(0, 1));
      abort   = (c == abort_at);
      sb_gnt  = in_req[c] ? !hold[c] : 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if (obs !== expv[c]) begin
        bad++;
        if (printed < 40) begin
          printed++;
          $display("FAIL %s cycle %0d: got %b expected %b", name, c, obs, expv[c]);
        end
      end
      if (obs[14]) n_en++;
      if (obs[10]) n_upd++;
      if (obs[4]) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      last_idx = obs[3:0];
      @(posedge clk);
      #1;
    end
    start = 1'b0; abort = 1'b0; sb_gnt = 1'b0; inverse = 1'b0;
    prev_mode[inst] = inv;
    prev_idx[inst]  = expv[ncyc-1][3:0];
  endtask

  int st [1:NR];
  int n_en, n_upd, n_done, done_cyc;
  logic [3:0] last_idx;

  task automatic clear_stalls();
    for (int r = 1; r <= NR; r++) st[r] = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (obs0 !== 17'd0) begin bad++; $display("FAIL reset_lat4: got %b expected 0", obs0); end
    total++;
    if (obs1 !== 17'd0) begin bad++; $display("FAIL reset_lat1: got %b expected 0", obs1); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_forward();
    clear_stalls();
    run_sched(0, 1'b0, st, -1, 1'b0, "forward", n_en, n_upd, n_done, done_cyc, last_idx);
    total++;
    if (n_en !== 41) begin bad++; $display("FAIL fwd_enable_count: got %0d expected 41", n_en); end
    total++;
    if (n_upd !== NR) begin bad++; $display("FAIL fwd_rcon_updates: got %0d expected %0d", n_upd, NR); end
    total++;
    if (done_cyc !== 2 + NR * 8) begin bad++; $display("FAIL fwd_done_cycle: got %0d expected %0d", done_cyc, 2 + NR * 8); end
    total++;
    if (last_idx !== 4'd10) begin bad++; $display("FAIL fwd_final_idx: got %0d expected 10", last_idx); end
  endtask

  task automatic test_grant_stall();
    clear_stalls();
    st[3] = 5;
    run_sched(0, 1'b0, st, -1, 1'b0, "grant_stall", n_en, n_upd, n_done, done_cyc, last_idx);
    total++;
    if (done_cyc !== 2 + NR * 8 + 5) begin bad++; $display("FAIL stall_done_cycle: got %0d expected %0d", done_cyc, 2 + NR * 8 + 5); end
  endtask

  task automatic test_inverse();
    for (int r = 1; r <= NR; r++) st[r] = $urandom_range(0, 3);
    run_sched(0, 1'b1, st, -1, 1'b1, "inverse", n_en, n_upd, n_done, done_cyc, last_idx);
    total++;
    if (n_done !== 1) begin bad++; $display("FAIL inv_single_done: got %0d expected 1", n_done); end
  endtask

  task automatic test_abort();
    clear_stalls();
    run_sched(0, 1'b0, st, 36, 1'b0, "abort_wait_r5", n_en, n_upd, n_done, done_cyc, last_idx);
    total++;
    if (n_done !== 0) begin bad++; $display("FAIL abort_no_done: got %0d expected 0", n_done); end
    total++;
    if (last_idx !== 4'd4) begin bad++; $display("FAIL abort_idx: got %0d expected 4", last_idx); end
    run_sched(0, 1'b0, st, -1, 1'b1, "rerun_after_abort", n_en, n_upd, n_done, done_cyc, last_idx);
    total++;
    if (done_cyc !== 2 + NR * 8) begin bad++; $display("FAIL rerun_done_cycle: got %0d expected %0d", done_cyc, 2 + NR * 8); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      for (int r = 1; r <= NR; r++) st[r] = $urandom_range(0, 4);
      run_sched(0, 1'($urandom_range(0, 1)), st, (i % 2 == 0) ? $urandom_range(2, 70) : -1,
                1'b1, "random", n_en, n_upd, n_done, done_cyc, last_idx);
    end
  endtask

  task automatic test_rst_mid_run();
    sel = 0; inverse = 1'b1; start = 1'b1; sb_gnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; inverse = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs0 !== 17'd0) begin bad++; $display("FAIL rst_mid_upd: got %b expected 0", obs0); end
    @(negedge clk);
    rst = 1'b0; sb_gnt = 1'b0;
    prev_mode[0] = 1'b0; prev_idx[0] = 4'd0;
    prev_mode[1] = 1'b0; prev_idx[1] = 4'd0;
    @(posedge clk); #1;
    clear_stalls();
    run_sched(0, 1'b0, st, -1, 1'b1, "after_rst", n_en, n_upd, n_done, done_cyc, last_idx);
    total++;
    if (n_done !== 1) begin bad++; $display("FAIL back_to_back_done: got %0d expected 1", n_done); end
  endtask

  task automatic test_lat1();
    clear_stalls();
    run_sched(1, 1'b0, st, -1, 1'b0, "lat1", n_en, n_upd, n_done, done_cyc, last_idx);
    total++;
    if (done_cyc !== 2 + NR * 5) begin bad++; $display("FAIL lat1_done_cycle: got %0d expected %0d", done_cyc, 2 + NR * 5); end
    for (int r = 1; r <= NR; r++) st[r] = $urandom_range(0, 3);
    run_sched(1, 1'b1, st, -1, 1'b1, "lat1_inverse", n_en, n_upd, n_done, done_cyc, last_idx);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; inverse = 1'b0; abort = 1'b0; sb_gnt = 1'b0; sel = 0;
    prev_mode[0] = 1'b0; prev_idx[0] = 4'd0;
    prev_mode[1] = 1'b0; prev_idx[1] = 4'd0;
    repeat (3) @(posedge clk);
    test_reset();
    test_forward();
    test_grant_stall();
    test_inverse();
    test_abort();
    test_random();
    test_rst_mid_run();
    test_lat1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
